icache: RTL and testbench

- Direct-mapped, read-only instruction cache. It is the responder end of the fetch-stage ICache_valid/ICache_ready handshake.
- Accepts fetch requests from the IF1 stage and returns one 32-bit instruction per accepted request.
- On a miss, it refills a whole line from the memory side over a burst read interface.

---
 rtl/icache.sv | 162 ++++++++++++++++
 tb/tb_icache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// ============================================================================
// Module : icache
// Brief  : Direct-mapped read-only instruction cache with burst line refill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4,
  parameter int WORD         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ICache_valid,
  input  logic [WORD-1:0] ICache_addr,
  output logic            ICache_ready,
  output logic [WORD-1:0] ICache_inst,
  output logic            ICache_accept,
  output logic            rd_req,
  output logic [WORD-1:0] rd_addr,
  input  logic            rd_rdy,
  input  logic            ret_valid,
  input  logic            ret_last,
  input  logic [WORD-1:0] ret_data
);

  localparam int c_tag_w     = WORD - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int c_cnt_w     = OFFSET_WIDTH - 2;
  localparam int c_words     = 2 ** c_cnt_w;
  localparam int c_num_lines = 2 ** INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                   r_state;
  logic [c_num_lines-1:0]   r_valid;
  logic [c_tag_w-1:0]       r_tag  [c_num_lines];
  logic [WORD-1:0]          r_data [c_num_lines][c_words];
  logic [WORD-1:0]          r_line [c_words];
  logic [c_cnt_w-1:0]       r_cnt;

  logic [c_tag_w-1:0]       r_req_tag;
  logic [INDEX_WIDTH-1:0]   r_req_index;
  logic [c_cnt_w-1:0]       r_req_word;

  logic                     w_hit;
  logic                     w_accepting;
  logic                     w_fill_done;
  logic [WORD-1:0]          w_fill_line [c_words];
  logic [WORD-1:0]          w_fill_word;
  logic                     w_unused;

  // Byte-lane bits of the fetch address carry no information for word fetches.
  assign w_unused = ^ICache_addr[1:0];

  assign w_hit = r_valid[r_req_index] && (r_tag[r_req_index] == r_req_tag);

  always_comb begin
    w_accepting = 1'b0;
    case (r_state)
      S_IDLE:   w_accepting = 1'b1;
      S_LOOKUP: w_accepting = w_hit;
      default:  w_accepting = 1'b0;
    endcase
  end

  assign ICache_accept = ICache_valid && w_accepting;
  assign w_fill_done   = (r_state == S_REFILL) && ret_valid && ret_last;

  // Line as it will be written: buffered beats with the arriving beat merged in.
  always_comb begin
    for (int w = 0; w < c_words; w++) begin
      w_fill_line[w] = (r_cnt == c_cnt_w'(w)) ? ret_data : r_line[w];
    end
  end

  assign w_fill_word = w_fill_line[r_req_word];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_req_tag    <= '0;
      r_req_index  <= '0;
      r_req_word   <= '0;
      ICache_ready <= 1'b0;
      ICache_inst  <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
    end else begin
      ICache_ready <= 1'b0;
      if (ICache_accept) begin
        r_req_tag   <= ICache_addr[WORD-1:INDEX_WIDTH+OFFSET_WIDTH];
        r_req_index <= ICache_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
        r_req_word  <= ICache_addr[OFFSET_WIDTH-1:2];
      end
      case (r_state)
        S_IDLE: begin
          if (ICache_accept) begin
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            ICache_ready <= 1'b1;
            ICache_inst  <= r_data[r_req_index][r_req_word];
            r_state      <= ICache_accept ? S_LOOKUP : S_IDLE;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= {r_req_tag, r_req_index, {OFFSET_WIDTH{1'b0}}};
            r_state <= S_MISS;
          end
        end
        S_MISS: begin
          if (rd_rdy) begin
            rd_req  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_fill_done) begin
            r_valid[r_req_index] <= 1'b1;
            ICache_ready         <= 1'b1;
            ICache_inst          <= w_fill_word;
            r_state              <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if ((r_state == S_REFILL) && ret_valid) begin
      r_line[r_cnt] <= ret_data;
      if (ret_last) begin
        r_tag[r_req_index]  <= r_req_tag;
        r_data[r_req_index] <= w_fill_line;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module : tb_icache
// Brief  : Self-checking bench for icache against a line-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ICache_valid;
  logic [31:0] ICache_addr;
  logic        ICache_ready;
  logic [31:0] ICache_inst;
  logic        ICache_accept;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int n_cmp  = 0;
  int n_fail = 0;

  bit          vld_m [256];
  logic [19:0] tag_m [256];

  icache #(.INDEX_WIDTH(8), .OFFSET_WIDTH(4), .WORD(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ICache_valid  (ICache_valid),
    .ICache_addr   (ICache_addr),
    .ICache_ready  (ICache_ready),
    .ICache_inst   (ICache_inst),
    .ICache_accept (ICache_accept),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_rdy        (rd_rdy),
    .ret_valid     (ret_valid),
    .ret_last      (ret_last),
    .ret_data      (ret_data)
  );

  always #5 clk = ~clk;

  // Backing memory contents; line 0x1C000000 holds 0x11,0x22,0x33,0x44.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if ({a[31:4], 4'b0000} == 32'h1C00_0000) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int dly, input bit gap);
    logic [7:0]  idx;
    logic [19:0] tg;
    logic [31:0] line;
    logic [31:0] exp;
    bit          hit;
    idx  = addr[11:4];
    tg   = addr[31:12];
    line = {addr[31:4], 4'b0000};
    exp  = mem_word(addr);
    hit  = vld_m[idx] && (tag_m[idx] == tg);

    ICache_valid = 1'b1;
    ICache_addr  = addr;
    #1 check("accept_idle", {31'd0, ICache_accept}, 32'd1);
    tick();
    ICache_valid = 1'b0;
    ICache_addr  = $urandom;
    check("ready_in_lookup", {31'd0, ICache_ready}, 32'd0);
    if (hit) begin
      tick();
      check("hit_ready", {31'd0, ICache_ready}, 32'd1);
      check("hit_inst", ICache_inst, exp);
      check("hit_no_rd_req", {31'd0, rd_req}, 32'd0);
      tick();
      check("hit_ready_drop", {31'd0, ICache_ready}, 32'd0);
    end else begin
      tick();
      check("miss_rd_req", {31'd0, rd_req}, 32'd1);
      check("miss_rd_addr", rd_addr, line);
      ICache_valid = 1'b1;
      ICache_addr  = $urandom;
      for (int i = 0; i < dly; i++) begin
        #1 check("miss_accept", {31'd0, ICache_accept}, 32'd0);
        tick();
        check("miss_rd_req_hold", {31'd0, rd_req}, 32'd1);
        check("miss_rd_addr_hold", rd_addr, line);
      end
      rd_rdy = 1'b1;
      #1 check("miss_accept_hs", {31'd0, ICache_accept}, 32'd0);
      tick();
      rd_rdy = 1'b0;
      check("rd_req_drop", {31'd0, rd_req}, 32'd0);
      for (int w = 0; w < 4; w++) begin
        if (gap && w > 0) begin
          ret_valid = 1'b0;
          ret_last  = 1'($urandom);
          ret_data  = $urandom;
          #1 check("refill_accept_gap", {31'd0, ICache_accept}, 32'd0);
          tick();
        end
        ret_valid = 1'b1;
        ret_last  = (w == 3);
        ret_data  = mem_word(line + 32'(4 * w));
        if (w == 3) ICache_valid = 1'b0;
        #1 check("refill_no_ready", {31'd0, ICache_ready}, 32'd0);
        if (w < 3) check("refill_accept", {31'd0, ICache_accept}, 32'd0);
        tick();
      end
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      check("resp_ready", {31'd0, ICache_ready}, 32'd1);
      check("resp_inst", ICache_inst, exp);
      ICache_valid = 1'b1;
      #1 check("resp_accept", {31'd0, ICache_accept}, 32'd0);
      ICache_valid = 1'b0;
      tick();
      check("resp_ready_drop", {31'd0, ICache_ready}, 32'd0);
      vld_m[idx] = 1'b1;
      tag_m[idx] = tg;
    end
  endtask

  // Four back-to-back fetches of a resident line.
  task automatic b2b(input logic [31:0] line);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        ICache_valid = 1'b1;
        ICache_addr  = line + 32'(4 * i);
      end else begin
        ICache_valid = 1'b0;
      end
      #1;
      if (i < 4) check("b2b_accept", {31'd0, ICache_accept}, 32'd1);
      if (i >= 2) begin
        check("b2b_ready", {31'd0, ICache_ready}, 32'd1);
        check("b2b_inst", ICache_inst, mem_word(line + 32'(4 * (i - 2))));
      end else begin
        check("b2b_ready_early", {31'd0, ICache_ready}, 32'd0);
      end
      tick();
    end
    check("b2b_ready_drop", {31'd0, ICache_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [19:0] tg;
    for (int i = 0; i < 256; i++) begin
      vld_m[i] = 1'b0;
      tag_m[i] = '0;
    end
    rst = 1'b0;
    ICache_valid = 1'b0;
    ICache_addr  = '0;
    rd_rdy = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, ICache_ready}, 32'd0);
    check("rst_inst", ICache_inst, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    rst = 1'b0;
    tick();

    do_fetch(32'h1C00_0008, 0, 1'b0);
    do_fetch(32'h1C00_000C, 0, 1'b0);
    b2b(32'h1C00_0000);
    do_fetch(32'h2C00_0000, 1, 1'b0);
    do_fetch(32'h1C00_0000, 1, 1'b0);
    do_fetch(32'h0000_1237, 5, 1'b1);
    do_fetch(32'h0000_1234, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       tg = 20'h1C000;
        1:       tg = 20'h2C000;
        2:       tg = 20'h00001;
        default: tg = 20'($urandom_range(32'h40000, 32'hFFFFF));
      endcase
      a = {tg, 8'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      do_fetch(a, $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 2) == 0) b2b({a[31:4], 4'b0000});
    end

    // Reset in the middle of a refill.
    ICache_valid = 1'b1;
    ICache_addr  = 32'h3000_0048;
    tick();
    ICache_valid = 1'b0;
    tick();
    check("mid_rd_req", {31'd0, rd_req}, 32'd1);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    for (int w = 0; w < 2; w++) begin
      ret_valid = 1'b1;
      ret_last  = 1'b0;
      ret_data  = mem_word(32'h3000_0040 + 32'(4 * w));
      tick();
    end
    ret_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, ICache_ready}, 32'd0);
    check("mid_rst_inst", ICache_inst, 32'd0);
    check("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("mid_rst_rd_addr", rd_addr, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) vld_m[i] = 1'b0;
    for (int w = 2; w < 4; w++) begin
      ret_valid = 1'b1;
      ret_last  = (w == 3);
      ret_data  = $urandom;
      tick();
      check("stray_beat_ready", {31'd0, ICache_ready}, 32'd0);
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    do_fetch(32'h3000_0048, 1, 1'b0);
    do_fetch(32'h1C00_0004, 0, 1'b1);
    do_fetch(32'h3000_0048, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
